// File: rtl/stdp_lif_pair.sv
// Pre/post leaky integrate-and-fire neuron pair joined by one plastic synapse.
// The pre neuron drives the post neuron through the registered weight. The
// weight adapts with a pair-based STDP rule whose step halves every 4 cycles
// of spike separation.

// Single LIF neuron: leaky integrate, fire at threshold, optional refractory.
module lif_neuron #(
    parameter int WIDTH      = 8,
    parameter int THRESH     = 128,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] cur_in,
    output logic             spike,
    output logic [WIDTH-1:0] state
);
    localparam logic [0:0] ST_INTEGRATE  = 1'b0;
    localparam logic [0:0] ST_REFRACTORY = 1'b1;

    // The counter holds the refractory cycles still to go after the current one.
    localparam int             RW       = (REFRAC > 1) ? $clog2(REFRAC) : 1;
    localparam logic [RW-1:0]  REF_LOAD = RW'((REFRAC > 0) ? REFRAC - 1 : 0);

    logic [0:0]    fsm;
    logic [RW-1:0] ref_cnt;
    logic [WIDTH:0]   sum_raw;
    logic [WIDTH-1:0] sum_sat;
    logic             fire;

    // Leak plus input, one extra bit of headroom, clamped to full scale.
    always_comb begin
        sum_raw = {1'b0, state} - {1'b0, (state >> LEAK_SHIFT)} + {1'b0, cur_in};
        sum_sat = sum_raw[WIDTH] ? '1 : sum_raw[WIDTH-1:0];
        fire    = ({1'b0, sum_sat} >= (WIDTH+1)'(THRESH));
    end

    // Neuron FSM; with ena low everything holds and the spike output reads 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= '0;
            spike   <= 1'b0;
            fsm     <= ST_INTEGRATE;
            ref_cnt <= '0;
        end else if (!ena) begin
            spike <= 1'b0;
        end else begin
            case (fsm)
                ST_INTEGRATE: begin
                    if (fire) begin
                        state <= '0;
                        spike <= 1'b1;
                        if (REFRAC > 0) begin
                            fsm     <= ST_REFRACTORY;
                            ref_cnt <= REF_LOAD;
                        end
                    end else begin
                        state <= sum_sat;
                        spike <= 1'b0;
                    end
                end
                default: begin
                    state <= '0;
                    spike <= 1'b0;
                    if (ref_cnt == '0) fsm <= ST_INTEGRATE;
                    else               ref_cnt <= ref_cnt - 1'b1;
                end
            endcase
        end
    end
endmodule

// Neuron pair with STDP-trained synapse.
module stdp_lif_pair #(
    parameter int WIDTH      = 8,
    parameter int THRESH     = 128,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int WINDOW     = 16,
    parameter int W_INIT     = 64,
    parameter int W_MAX      = 255,
    parameter int A_PLUS     = 8,
    parameter int A_MINUS    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] pre_current,
    input  logic [WIDTH-1:0] post_current,
    input  logic             w_load,
    input  logic [WIDTH-1:0] w_in,
    output logic             pre_spike,
    output logic             post_spike,
    output logic             w_update,
    output logic             w_sat,
    output logic [WIDTH-1:0] pre_state,
    output logic [WIDTH-1:0] post_state,
    output logic [WIDTH-1:0] weight
);
    localparam int               DTW      = $clog2(WINDOW + 1);
    localparam logic [DTW-1:0]   WIN_V    = DTW'(WINDOW);
    localparam logic [WIDTH-1:0] W_MAX_V  = WIDTH'(W_MAX);
    localparam logic [WIDTH-1:0] A_PLUS_V = WIDTH'(A_PLUS);
    localparam logic [WIDTH-1:0] A_MIN_V  = WIDTH'(A_MINUS);
    localparam logic             SAT_INIT = (W_INIT == W_MAX) || (W_INIT == 0);

    logic [DTW-1:0]   pre_dt, post_dt;
    logic [WIDTH:0]   post_sum;
    logic [WIDTH-1:0] post_in;
    logic [WIDTH-1:0] delta_p, delta_m, pot_val, dep_val, load_val, w_next;
    logic [WIDTH:0]   pot_sum;
    logic             pot_ok, dep_ok, upd_next;

    // Post drive: external current plus the synaptic weight on a pre spike.
    always_comb begin
        post_sum = {1'b0, post_current} + {1'b0, (pre_spike ? weight : '0)};
        post_in  = post_sum[WIDTH] ? '1 : post_sum[WIDTH-1:0];
    end

    lif_neuron #(.WIDTH(WIDTH), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC))
    u_pre (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cur_in(pre_current),
        .spike(pre_spike), .state(pre_state)
    );

    lif_neuron #(.WIDTH(WIDTH), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC))
    u_post (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cur_in(post_in),
        .spike(post_spike), .state(post_state)
    );

    // Cycles since the last spike of each neuron, parked at WINDOW when stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_dt  <= WIN_V;
            post_dt <= WIN_V;
        end else if (ena) begin
            pre_dt  <= pre_spike  ? '0 : ((pre_dt  >= WIN_V) ? WIN_V : pre_dt  + 1'b1);
            post_dt <= post_spike ? '0 : ((post_dt >= WIN_V) ? WIN_V : post_dt + 1'b1);
        end
    end

    // STDP rule: step size halves per 4 cycles of separation; load wins.
    always_comb begin
        delta_p  = A_PLUS_V >> (pre_dt >> 2);
        delta_m  = A_MIN_V  >> (post_dt >> 2);
        pot_ok   = post_spike && !pre_spike && (pre_dt  < WIN_V);
        dep_ok   = pre_spike  && !post_spike && (post_dt < WIN_V);
        pot_sum  = {1'b0, weight} + {1'b0, delta_p};
        pot_val  = (pot_sum > {1'b0, W_MAX_V}) ? W_MAX_V : pot_sum[WIDTH-1:0];
        dep_val  = (delta_m > weight) ? '0 : weight - delta_m;
        load_val = (w_in > W_MAX_V) ? W_MAX_V : w_in;
        w_next   = weight;
        upd_next = 1'b0;
        if (w_load) begin
            w_next = load_val;
        end else if (pot_ok) begin
            w_next   = pot_val;
            upd_next = 1'b1;
        end else if (dep_ok) begin
            w_next   = dep_val;
            upd_next = 1'b1;
        end
    end

    // Weight register with its update pulse and saturation flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight   <= WIDTH'(W_INIT);
            w_update <= 1'b0;
            w_sat    <= SAT_INIT;
        end else if (ena) begin
            weight   <= w_next;
            w_update <= upd_next;
            w_sat    <= (w_next == W_MAX_V) || (w_next == '0);
        end else begin
            w_update <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stdp_lif_pair.sv
// Directed scenarios plus random traffic for stdp_lif_pair, each cycle checked
// against an integer model of the neuron pair and its plasticity rule.
module tb_stdp_lif_pair;
    localparam int MAXV = 255, TH = 128, LS = 3, RF = 2, WIN = 16;
    localparam int WINIT = 64, WMAX = 255, AP = 8, AM = 8;

    logic       clk = 1'b0;
    logic       rst_n, ena, w_load;
    logic [7:0] pre_current, post_current, w_in;
    logic       pre_spike, post_spike, w_update, w_sat;
    logic [7:0] pre_state, post_state, weight;

    int checks = 0;
    int failures = 0;

    // model state
    int m_pre_st, m_post_st, m_pre_rf, m_post_rf, m_pre_sp, m_post_sp;
    int m_pre_dt, m_post_dt, m_w, m_upd;

    stdp_lif_pair dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pre_current(pre_current),
        .post_current(post_current), .w_load(w_load), .w_in(w_in),
        .pre_spike(pre_spike), .post_spike(post_spike), .w_update(w_update),
        .w_sat(w_sat), .pre_state(pre_state), .post_state(post_state), .weight(weight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One neuron step: rf counts remaining refractory cycles.
    task automatic nrn(inout int st, inout int rf, output int sp, input int in);
        int s;
        if (rf > 0) begin
            st = 0; sp = 0; rf = rf - 1;
        end else begin
            s = st - st / (1 << LS) + in;
            if (s > MAXV) s = MAXV;
            if (s >= TH) begin st = 0; sp = 1; rf = RF; end
            else begin st = s; sp = 0; end
        end
    endtask

    task automatic model_step(input bit r, input bit e, input int pc, input int qc,
                              input bit wl, input int wi);
        int o_pre, o_post, o_pdt, o_qdt, o_w, pin, d;
        o_pre = m_pre_sp; o_post = m_post_sp; o_pdt = m_pre_dt; o_qdt = m_post_dt; o_w = m_w;
        if (!r) begin
            m_pre_st = 0; m_post_st = 0; m_pre_rf = 0; m_post_rf = 0;
            m_pre_sp = 0; m_post_sp = 0; m_pre_dt = WIN; m_post_dt = WIN;
            m_w = WINIT; m_upd = 0;
        end else if (!e) begin
            m_pre_sp = 0; m_post_sp = 0; m_upd = 0;
        end else begin
            pin = qc + (o_pre != 0 ? o_w : 0);
            if (pin > MAXV) pin = MAXV;
            nrn(m_pre_st, m_pre_rf, m_pre_sp, pc);
            nrn(m_post_st, m_post_rf, m_post_sp, pin);
            m_pre_dt  = (o_pre  != 0) ? 0 : ((o_pdt + 1 > WIN) ? WIN : o_pdt + 1);
            m_post_dt = (o_post != 0) ? 0 : ((o_qdt + 1 > WIN) ? WIN : o_qdt + 1);
            m_upd = 0;
            if (wl) begin
                m_w = (wi > WMAX) ? WMAX : wi;
            end else if (o_post != 0 && o_pre == 0 && o_pdt < WIN) begin
                d = AP / (1 << (o_pdt / 4));
                m_w = (o_w + d > WMAX) ? WMAX : o_w + d;
                m_upd = 1;
            end else if (o_pre != 0 && o_post == 0 && o_qdt < WIN) begin
                d = AM / (1 << (o_qdt / 4));
                m_w = (o_w - d < 0) ? 0 : o_w - d;
                m_upd = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("pre_spike",  int'(pre_spike),  m_pre_sp);
        chk("post_spike", int'(post_spike), m_post_sp);
        chk("pre_state",  int'(pre_state),  m_pre_st);
        chk("post_state", int'(post_state), m_post_st);
        chk("weight",     int'(weight),     m_w);
        chk("w_update",   int'(w_update),   m_upd);
        chk("w_sat",      int'(w_sat),      (m_w == WMAX || m_w == 0) ? 1 : 0);
    endtask

    // Apply inputs, clock once, advance model, check on the falling edge.
    task automatic cyc(input bit r, input bit e, input int pc, input int qc,
                       input bit wl, input int wi);
        rst_n = r; ena = e; pre_current = 8'(pc); post_current = 8'(qc);
        w_load = wl; w_in = 8'(wi);
        @(posedge clk);
        model_step(r, e, pc, qc, wl, wi);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0);
    endtask

    // Reset with noise on ena/w_load/currents, which reset must override.
    task automatic rst(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255), 1, $urandom_range(0, 255));
    endtask

    int s_pre, s_post, s_w;

    initial begin
        rst_n = 0; ena = 0; w_load = 0; pre_current = 0; post_current = 0; w_in = 0;
        m_pre_st = 0; m_post_st = 0; m_pre_rf = 0; m_post_rf = 0; m_pre_sp = 0;
        m_post_sp = 0; m_pre_dt = WIN; m_post_dt = WIN; m_w = WINIT; m_upd = 0;

        // quiet run after reset
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_weight", int'(weight), 64);
        chk("rst_pre_state", int'(pre_state), 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("idle_upd", int'(w_update), 0);
            chk("idle_spk", int'(pre_spike | post_spike), 0);
        end
        chk("idle_weight", int'(weight), 64);

        // held pre drive: spike period REFRAC+1
        rst(2);
        for (int k = 1; k <= 9; k++) begin
            cyc(1, 1, 128, 0, 0, 0);
            chk("held_pre_spike", int'(pre_spike), (k % 3 == 1) ? 1 : 0);
            chk("held_pre_state", int'(pre_state), 0);
        end

        // loaded weight drives post; potentiation at dt=0
        rst(2);
        cyc(1, 1, 0, 0, 1, 200);
        chk("load200", int'(weight), 200);
        cyc(1, 1, 128, 0, 0, 0);
        chk("n_pre_spike", int'(pre_spike), 1);
        idle(1);
        chk("n1_post_spike", int'(post_spike), 1);
        idle(1);
        chk("n2_weight", int'(weight), 208);
        chk("n2_w_update", int'(w_update), 1);

        // depression at post_dt=4
        rst(2);
        cyc(1, 1, 0, 128, 0, 0);
        chk("m_post_spike", int'(post_spike), 1);
        idle(4);
        cyc(1, 1, 128, 0, 0, 0);
        chk("m5_pre_spike", int'(pre_spike), 1);
        idle(1);
        chk("m6_weight", int'(weight), 60);
        chk("m6_w_update", int'(w_update), 1);

        // saturation at both ends
        rst(2);
        cyc(1, 1, 0, 0, 1, 252);
        idle(20);
        for (int r = 0; r < 2; r++) begin
            cyc(1, 1, 128, 0, 0, 0);
            idle(2);
            chk("pot_sat_weight", int'(weight), 255);
            chk("pot_sat_upd", int'(w_update), 1);
            idle(20);
        end
        chk("pot_sat_flag", int'(w_sat), 1);
        cyc(1, 1, 0, 0, 1, 3);
        idle(20);
        cyc(1, 1, 0, 128, 0, 0);
        cyc(1, 1, 128, 0, 0, 0);
        idle(1);
        chk("dep_sat_weight", int'(weight), 0);
        chk("dep_sat_flag", int'(w_sat), 1);
        chk("dep_sat_upd", int'(w_update), 1);

        // coincident spikes leave weight alone
        rst(2);
        cyc(1, 1, 128, 128, 0, 0);
        chk("coinc_both", int'(pre_spike & post_spike), 1);
        idle(1);
        chk("coinc_weight", int'(weight), 64);
        chk("coinc_upd", int'(w_update), 0);

        // ena low freezes everything and ignores w_load
        rst(2);
        for (int i = 0; i < 3; i++) cyc(1, 1, 40, 30, 0, 0);
        s_pre = m_pre_st; s_post = m_post_st; s_w = m_w;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), 1, $urandom_range(0, 255));
            chk("frz_pre_state", int'(pre_state), s_pre);
            chk("frz_post_state", int'(post_state), s_post);
            chk("frz_weight", int'(weight), s_w);
            chk("frz_spk", int'(pre_spike | post_spike | w_update), 0);
        end
        idle(3);

        // reset aborts a refractory period
        rst(2);
        cyc(1, 1, 128, 0, 0, 0);
        cyc(1, 1, 128, 0, 0, 0);
        chk("refr_pre_spike", int'(pre_spike), 0);
        cyc(0, 1, 128, 0, 1, 9);
        chk("rst_mid_weight", int'(weight), 64);
        chk("rst_mid_spk", int'(pre_spike | post_spike | w_update), 0);
        cyc(1, 1, 128, 0, 0, 0);
        chk("rst_mid_refire", int'(pre_spike), 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 60),
                ($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 60),
                ($urandom_range(0, 29) == 0), $urandom_range(0, 255));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
